floo_multi_chan_traffic_monitor: RTL and testbench



---
 rtl/floo_traffic_monitor_pkg.sv | 45 ++++
 rtl/floo_traffic_monitor_chan.sv | 136 +++++++++++++
 rtl/floo_multi_chan_traffic_monitor.sv | 140 ++++++++++++++
 tb/tb_floo_multi_chan_traffic_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_traffic_monitor_pkg.sv
// Shared types and helpers for the FlooNoC multi-channel traffic monitor.
//   mon_state_e  : drain/end-of-simulation FSM encoding (3 bits)
//   sat_res_t    : result of a saturating +1/-1 step (value plus error flags)
//   sat_add_sub  : saturating increment/decrement on a 64-bit container;
//                  callers zero-extend their counter and pass its own maximum.
package floo_traffic_monitor_pkg;

    typedef enum logic [2:0] {
        MON_IDLE    = 3'd0,
        MON_RUN     = 3'd1,
        MON_DRAIN   = 3'd2,
        MON_DONE    = 3'd3,
        MON_TIMEOUT = 3'd4
    } mon_state_e;

    // Widest counter the helper supports; counters must be narrower than this.
    localparam int unsigned SatWidth = 64;

    typedef struct packed {
        logic [SatWidth-1:0] value;
        logic                ovf;
        logic                unf;
    } sat_res_t;

    // inc and dec together cancel out. At the limit the value holds and the
    // matching flag is raised instead of wrapping.
    function automatic sat_res_t sat_add_sub(input logic [SatWidth-1:0] val,
                                             input logic                inc,
                                             input logic                dec,
                                             input logic [SatWidth-1:0] max_val);
        sat_res_t res;
        res.value = val;
        res.ovf   = 1'b0;
        res.unf   = 1'b0;
        if (inc && !dec) begin
            if (val >= max_val) res.ovf = 1'b1;
            else                res.value = val + 64'd1;
        end else if (dec && !inc) begin
            if (val == '0) res.unf = 1'b1;
            else           res.value = val - 64'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/floo_traffic_monitor_chan.sv
// One monitored AXI channel: outstanding read/write counters, total beat
// counters, per-window beat accumulators and sticky error flags.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cnt_en_i               counting enable (broadcast from the top FSM)
//   win_wrap_i             last cycle of the current window (broadcast)
//   ar/aw/r/w/r_last/b_hs_i handshake strobes of this channel
//   ar/aw_in_flight_o      outstanding reads / writes
//   rd/wr_beats_o          total R / W beats
//   win_rd/wr_beats_o      beats of the last completed window
//   err_underflow_o        sticky: completion seen with nothing outstanding
//   err_overflow_o         sticky: any counter hit its saturation limit
module floo_traffic_monitor_chan
    import floo_traffic_monitor_pkg::*;
#(
    parameter int unsigned CntWidth      = 32,   // must be < SatWidth
    parameter int unsigned InFlightWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cnt_en_i,
    input  logic                     win_wrap_i,
    input  logic                     ar_hs_i,
    input  logic                     aw_hs_i,
    input  logic                     r_hs_i,
    input  logic                     w_hs_i,
    input  logic                     r_last_hs_i,
    input  logic                     b_hs_i,
    output logic [InFlightWidth-1:0] ar_in_flight_o,
    output logic [InFlightWidth-1:0] aw_in_flight_o,
    output logic [CntWidth-1:0]      rd_beats_o,
    output logic [CntWidth-1:0]      wr_beats_o,
    output logic [CntWidth-1:0]      win_rd_beats_o,
    output logic [CntWidth-1:0]      win_wr_beats_o,
    output logic                     err_underflow_o,
    output logic                     err_overflow_o
);

    localparam logic [SatWidth-1:0] InFlightMax = (64'd1 << InFlightWidth) - 64'd1;
    localparam logic [SatWidth-1:0] CntMax      = (64'd1 << CntWidth) - 64'd1;

    logic [InFlightWidth-1:0] ar_q, ar_d, aw_q, aw_d;
    logic [CntWidth-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CntWidth-1:0]      rd_acc_q, rd_acc_d, wr_acc_q, wr_acc_d;
    logic [CntWidth-1:0]      win_rd_q, win_rd_d, win_wr_q, win_wr_d;
    logic                     unf_q, unf_d, ovf_q, ovf_d;

    sat_res_t ar_res, aw_res, rd_res, wr_res, rd_acc_res, wr_acc_res;

    always_comb begin
        ar_res     = sat_add_sub(SatWidth'(ar_q), ar_hs_i, r_last_hs_i, InFlightMax);
        aw_res     = sat_add_sub(SatWidth'(aw_q), aw_hs_i, b_hs_i, InFlightMax);
        rd_res     = sat_add_sub(SatWidth'(rd_q), r_hs_i, 1'b0, CntMax);
        wr_res     = sat_add_sub(SatWidth'(wr_q), w_hs_i, 1'b0, CntMax);
        rd_acc_res = sat_add_sub(SatWidth'(rd_acc_q), r_hs_i, 1'b0, CntMax);
        wr_acc_res = sat_add_sub(SatWidth'(wr_acc_q), w_hs_i, 1'b0, CntMax);

        ar_d     = ar_q;
        aw_d     = aw_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rd_acc_d = rd_acc_q;
        wr_acc_d = wr_acc_q;
        win_rd_d = win_rd_q;
        win_wr_d = win_wr_q;
        unf_d    = unf_q;
        ovf_d    = ovf_q;

        if (cnt_en_i) begin
            ar_d  = ar_res.value[InFlightWidth-1:0];
            aw_d  = aw_res.value[InFlightWidth-1:0];
            rd_d  = rd_res.value[CntWidth-1:0];
            wr_d  = wr_res.value[CntWidth-1:0];
            unf_d = unf_q | ar_res.unf | aw_res.unf;
            ovf_d = ovf_q | ar_res.ovf | aw_res.ovf | rd_res.ovf | wr_res.ovf;
            // The wrap cycle's own beat belongs to the window being closed.
            if (win_wrap_i) begin
                win_rd_d = rd_acc_res.value[CntWidth-1:0];
                win_wr_d = wr_acc_res.value[CntWidth-1:0];
                rd_acc_d = '0;
                wr_acc_d = '0;
            end else begin
                rd_acc_d = rd_acc_res.value[CntWidth-1:0];
                wr_acc_d = wr_acc_res.value[CntWidth-1:0];
            end
        end
    end

    // Accumulators never exceed the totals, so their flags carry no news.
    logic unused_res_bits;
    assign unused_res_bits = ^{ar_res.value[SatWidth-1:InFlightWidth],
                               aw_res.value[SatWidth-1:InFlightWidth],
                               rd_res.value[SatWidth-1:CntWidth],
                               wr_res.value[SatWidth-1:CntWidth],
                               rd_acc_res.value[SatWidth-1:CntWidth],
                               wr_acc_res.value[SatWidth-1:CntWidth],
                               rd_res.unf, wr_res.unf,
                               rd_acc_res.ovf, rd_acc_res.unf,
                               wr_acc_res.ovf, wr_acc_res.unf};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_q     <= '0;
            aw_q     <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            rd_acc_q <= '0;
            wr_acc_q <= '0;
            win_rd_q <= '0;
            win_wr_q <= '0;
            unf_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ar_q     <= ar_d;
            aw_q     <= aw_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rd_acc_q <= rd_acc_d;
            wr_acc_q <= wr_acc_d;
            win_rd_q <= win_rd_d;
            win_wr_q <= win_wr_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ar_in_flight_o  = ar_q;
    assign aw_in_flight_o  = aw_q;
    assign rd_beats_o      = rd_q;
    assign wr_beats_o      = wr_q;
    assign win_rd_beats_o  = win_rd_q;
    assign win_wr_beats_o  = win_wr_q;
    assign err_underflow_o = unf_q;
    assign err_overflow_o  = ovf_q;

endmodule

// File: rtl/floo_multi_chan_traffic_monitor.sv
// Multi-channel traffic and end-of-simulation monitor for FlooNoC test nodes.
// Holds the drain FSM, sticky end-of-sim flags, the bandwidth window timer and
// the drain timer; per-channel counting lives in floo_traffic_monitor_chan.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   en_i                               monitoring enable (low pauses counting)
//   eos_i                              per-channel end-of-sim level
//   ar/aw/r/w/r_last/b_hs_i            per-channel handshake strobes
//   ar/aw_in_flight_o, rd/wr_beats_o   per-channel counters
//   win_rd/wr_beats_o, win_valid_o     last completed window and its update pulse
//   state_o, done_o, timeout_o         FSM state and sticky completion flags
//   err_underflow_o, err_overflow_o    per-channel sticky error flags
module floo_multi_chan_traffic_monitor
    import floo_traffic_monitor_pkg::*;
#(
    parameter int unsigned NumChannels   = 2,
    parameter int unsigned CntWidth      = 32,
    parameter int unsigned InFlightWidth = 8,
    parameter int unsigned WindowCycles  = 1024,
    parameter int unsigned DrainTimeout  = 4096
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       en_i,
    input  logic [NumChannels-1:0]                     eos_i,
    input  logic [NumChannels-1:0]                     ar_hs_i,
    input  logic [NumChannels-1:0]                     aw_hs_i,
    input  logic [NumChannels-1:0]                     r_hs_i,
    input  logic [NumChannels-1:0]                     w_hs_i,
    input  logic [NumChannels-1:0]                     r_last_hs_i,
    input  logic [NumChannels-1:0]                     b_hs_i,
    output logic [NumChannels-1:0][InFlightWidth-1:0]  ar_in_flight_o,
    output logic [NumChannels-1:0][InFlightWidth-1:0]  aw_in_flight_o,
    output logic [NumChannels-1:0][CntWidth-1:0]       rd_beats_o,
    output logic [NumChannels-1:0][CntWidth-1:0]       wr_beats_o,
    output logic [NumChannels-1:0][CntWidth-1:0]       win_rd_beats_o,
    output logic [NumChannels-1:0][CntWidth-1:0]       win_wr_beats_o,
    output logic                                       win_valid_o,
    output logic [2:0]                                 state_o,
    output logic                                       done_o,
    output logic                                       timeout_o,
    output logic [NumChannels-1:0]                     err_underflow_o,
    output logic [NumChannels-1:0]                     err_overflow_o
);

    localparam int unsigned WinW   = $clog2(WindowCycles);
    localparam int unsigned DrainW = $clog2(DrainTimeout + 1);

    mon_state_e             state_q;
    logic [NumChannels-1:0] eos_q;
    logic [WinW-1:0]        win_timer_q;
    logic [DrainW-1:0]      drain_timer_q;
    logic                   win_valid_q, done_q, timeout_q;

    logic                   cnt_en, win_wrap, all_eos, all_drained;
    logic [NumChannels-1:0] chan_busy;

    assign cnt_en   = en_i && (state_q == MON_RUN || state_q == MON_DRAIN);
    assign win_wrap = cnt_en && (win_timer_q == WinW'(WindowCycles - 1));
    // The current cycle's eos_i counts toward leaving RUN.
    assign all_eos  = &(eos_q | eos_i);
    assign all_drained = ~|chan_busy;

    for (genvar g = 0; g < NumChannels; g++) begin : gen_chan
        floo_traffic_monitor_chan #(
            .CntWidth      (CntWidth),
            .InFlightWidth (InFlightWidth)
        ) i_chan (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .cnt_en_i        (cnt_en),
            .win_wrap_i      (win_wrap),
            .ar_hs_i         (ar_hs_i[g]),
            .aw_hs_i         (aw_hs_i[g]),
            .r_hs_i          (r_hs_i[g]),
            .w_hs_i          (w_hs_i[g]),
            .r_last_hs_i     (r_last_hs_i[g]),
            .b_hs_i          (b_hs_i[g]),
            .ar_in_flight_o  (ar_in_flight_o[g]),
            .aw_in_flight_o  (aw_in_flight_o[g]),
            .rd_beats_o      (rd_beats_o[g]),
            .wr_beats_o      (wr_beats_o[g]),
            .win_rd_beats_o  (win_rd_beats_o[g]),
            .win_wr_beats_o  (win_wr_beats_o[g]),
            .err_underflow_o (err_underflow_o[g]),
            .err_overflow_o  (err_overflow_o[g])
        );
        assign chan_busy[g] = (|ar_in_flight_o[g]) || (|aw_in_flight_o[g]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= MON_IDLE;
            eos_q         <= '0;
            win_timer_q   <= '0;
            drain_timer_q <= '0;
            win_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            eos_q       <= eos_q | eos_i;
            win_valid_q <= win_wrap;
            if (cnt_en) begin
                win_timer_q <= win_wrap ? '0 : win_timer_q + WinW'(1);
            end
            unique case (state_q)
                MON_IDLE: begin
                    if (en_i) state_q <= MON_RUN;
                end
                MON_RUN: begin
                    if (en_i && all_eos) begin
                        state_q       <= MON_DRAIN;
                        drain_timer_q <= '0;
                    end
                end
                MON_DRAIN: begin
                    // Draining wins over the timeout if both hold together.
                    if (en_i) begin
                        if (all_drained) begin
                            state_q <= MON_DONE;
                            done_q  <= 1'b1;
                        end else if (drain_timer_q == DrainW'(DrainTimeout - 1)) begin
                            state_q   <= MON_TIMEOUT;
                            timeout_q <= 1'b1;
                        end else begin
                            drain_timer_q <= drain_timer_q + DrainW'(1);
                        end
                    end
                end
                default: ;  // DONE and TIMEOUT hold until reset
            endcase
        end
    end

    assign win_valid_o = win_valid_q;
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_floo_multi_chan_traffic_monitor.sv
module tb_floo_multi_chan_traffic_monitor;
    import floo_traffic_monitor_pkg::*;

    localparam int N   = 2;
    localparam int CW  = 16;
    localparam int IFW = 3;
    localparam int WIN = 8;
    localparam int DT  = 16;
    localparam int     IF_MAX  = 7;
    localparam longint CNT_MAX = 65535;

    logic clk = 1'b0;
    logic rst_n, en;
    logic [N-1:0] eos, ar_hs, aw_hs, r_hs, w_hs, r_last, b_hs;
    logic [N-1:0][IFW-1:0] ar_if, aw_if;
    logic [N-1:0][CW-1:0]  rd_b, wr_b, win_rd, win_wr;
    logic       win_valid, done, tmo;
    logic [2:0] state;
    logic [N-1:0] unf, ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    mon_state_e m_state;
    int     m_ar[N], m_aw[N];
    longint m_rd[N], m_wr[N], m_acc_rd[N], m_acc_wr[N], m_wrd[N], m_wwr[N];
    bit     m_unf[N], m_ovf[N], m_eos[N];
    bit     m_wv, m_done, m_to;
    int     m_counted, m_drain;

    floo_multi_chan_traffic_monitor #(
        .NumChannels(N), .CntWidth(CW), .InFlightWidth(IFW),
        .WindowCycles(WIN), .DrainTimeout(DT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .eos_i(eos),
        .ar_hs_i(ar_hs), .aw_hs_i(aw_hs), .r_hs_i(r_hs), .w_hs_i(w_hs),
        .r_last_hs_i(r_last), .b_hs_i(b_hs),
        .ar_in_flight_o(ar_if), .aw_in_flight_o(aw_if),
        .rd_beats_o(rd_b), .wr_beats_o(wr_b),
        .win_rd_beats_o(win_rd), .win_wr_beats_o(win_wr),
        .win_valid_o(win_valid), .state_o(state), .done_o(done),
        .timeout_o(tmo), .err_underflow_o(unf), .err_overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = MON_IDLE;
        for (int c = 0; c < N; c++) begin
            m_ar[c] = 0; m_aw[c] = 0; m_rd[c] = 0; m_wr[c] = 0;
            m_acc_rd[c] = 0; m_acc_wr[c] = 0; m_wrd[c] = 0; m_wwr[c] = 0;
            m_unf[c] = 0; m_ovf[c] = 0; m_eos[c] = 0;
        end
        m_wv = 0; m_done = 0; m_to = 0; m_counted = 0; m_drain = 0;
    endtask

    // One clock of the behavioural model, using the inputs applied this cycle.
    task automatic model_step();
        bit act, drained, all_eos;
        act = en && (m_state == MON_RUN || m_state == MON_DRAIN);
        drained = 1; all_eos = 1;
        for (int c = 0; c < N; c++) begin
            if (m_ar[c] != 0 || m_aw[c] != 0) drained = 0;
            m_eos[c] = m_eos[c] | eos[c];
            if (!m_eos[c]) all_eos = 0;
        end
        m_wv = 0;
        case (m_state)
            MON_IDLE: if (en) m_state = MON_RUN;
            MON_RUN:  if (en && all_eos) begin m_state = MON_DRAIN; m_drain = 0; end
            MON_DRAIN: if (en) begin
                if (drained) begin m_state = MON_DONE; m_done = 1; end
                else begin
                    m_drain++;
                    if (m_drain == DT) begin m_state = MON_TIMEOUT; m_to = 1; end
                end
            end
            default: ;
        endcase
        if (act) begin
            m_counted++;
            m_wv = (m_counted % WIN) == 0;
            for (int c = 0; c < N; c++) begin
                if (ar_hs[c] && !r_last[c]) begin
                    if (m_ar[c] == IF_MAX) m_ovf[c] = 1; else m_ar[c]++;
                end else if (r_last[c] && !ar_hs[c]) begin
                    if (m_ar[c] == 0) m_unf[c] = 1; else m_ar[c]--;
                end
                if (aw_hs[c] && !b_hs[c]) begin
                    if (m_aw[c] == IF_MAX) m_ovf[c] = 1; else m_aw[c]++;
                end else if (b_hs[c] && !aw_hs[c]) begin
                    if (m_aw[c] == 0) m_unf[c] = 1; else m_aw[c]--;
                end
                if (r_hs[c]) begin if (m_rd[c] == CNT_MAX) m_ovf[c] = 1; else m_rd[c]++; end
                if (w_hs[c]) begin if (m_wr[c] == CNT_MAX) m_ovf[c] = 1; else m_wr[c]++; end
                m_acc_rd[c] = (m_acc_rd[c] + r_hs[c] > CNT_MAX) ? CNT_MAX : m_acc_rd[c] + r_hs[c];
                m_acc_wr[c] = (m_acc_wr[c] + w_hs[c] > CNT_MAX) ? CNT_MAX : m_acc_wr[c] + w_hs[c];
                if (m_wv) begin
                    m_wrd[c] = m_acc_rd[c]; m_acc_rd[c] = 0;
                    m_wwr[c] = m_acc_wr[c]; m_acc_wr[c] = 0;
                end
            end
        end
    endtask

    task automatic clear_inputs();
        eos = '0; ar_hs = '0; aw_hs = '0; r_hs = '0; w_hs = '0; r_last = '0; b_hs = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; clear_inputs();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== MON_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, MON_IDLE); end
        total++; if (done !== 1'b0 || tmo !== 1'b0 || win_valid !== 1'b0) begin
            bad++; $display("FAIL reset_flags got done=%b tmo=%b wv=%b want 0", done, tmo, win_valid); end
        total++; if (ar_if !== '0 || aw_if !== '0 || rd_b !== '0 || wr_b !== '0 || win_rd !== '0 || win_wr !== '0) begin
            bad++; $display("FAIL reset_counters got ar=%h aw=%h rd=%h wr=%h want 0", ar_if, aw_if, rd_b, wr_b); end
        total++; if (unf !== '0 || ovf !== '0) begin bad++; $display("FAIL reset_err got unf=%b ovf=%b want 0", unf, ovf); end
        tick();  // en low: stays IDLE
        total++; if (state !== MON_IDLE) begin bad++; $display("FAIL idle_hold got=%0d want=%0d", state, MON_IDLE); end
    endtask

    task automatic test_read_drain();
        do_reset();
        en = 1; tick();
        total++; if (state !== MON_RUN) begin bad++; $display("FAIL run_entry got=%0d want=%0d", state, MON_RUN); end
        for (int i = 0; i < 3; i++) begin ar_hs = 2'b01; tick(); end
        ar_hs = '0;
        total++; if (ar_if[0] !== 3'd3) begin bad++; $display("FAIL rd_inflight3 got=%0d want=3", ar_if[0]); end
        for (int i = 0; i < 12; i++) begin
            r_hs = 2'b01; r_last = (i % 4 == 3) ? 2'b01 : 2'b00; tick();
        end
        r_hs = '0; r_last = '0;
        total++; if (ar_if[0] !== 3'd0 || rd_b[0] !== 16'd12) begin
            bad++; $display("FAIL rd_beats got inflight=%0d beats=%0d want 0/12", ar_if[0], rd_b[0]); end
        eos = 2'b11; tick();
        total++; if (state !== MON_DRAIN || done !== 1'b0) begin
            bad++; $display("FAIL drain_entry got state=%0d done=%b want %0d/0", state, done, MON_DRAIN); end
        tick();
        total++; if (state !== MON_DONE || done !== 1'b1 || tmo !== 1'b0) begin
            bad++; $display("FAIL done_rise got state=%0d done=%b tmo=%b want %0d/1/0", state, done, tmo, MON_DONE); end
        total++; if (state !== m_state || done !== m_done) begin
            bad++; $display("FAIL done_model got state=%0d want=%0d", state, m_state); end
        r_hs = 2'b11; ar_hs = 2'b11;
        repeat (3) tick();
        clear_inputs();
        total++; if (rd_b[0] !== 16'd12 || ar_if[0] !== 3'd0 || rd_b[1] !== 16'd0) begin
            bad++; $display("FAIL freeze got rd0=%0d ar0=%0d rd1=%0d want 12/0/0", rd_b[0], ar_if[0], rd_b[1]); end
    endtask

    task automatic test_window();
        do_reset();
        en = 1; tick();
        for (int k = 0; k < 18; k++) begin
            r_hs = (k < 4) ? 2'b01 : 2'b00;
            tick();
            total++; if (win_valid !== ((k == 7) || (k == 15))) begin
                bad++; $display("FAIL win_valid k=%0d got=%b want=%b", k, win_valid, (k == 7) || (k == 15)); end
            if (k == 7) begin
                total++; if (win_rd[0] !== 16'd4) begin bad++; $display("FAIL win1_beats got=%0d want=4", win_rd[0]); end
            end
            if (k == 15) begin
                total++; if (win_rd[0] !== 16'd0) begin bad++; $display("FAIL win2_beats got=%0d want=0", win_rd[0]); end
            end
        end
        r_hs = '0;
        total++; if (rd_b[0] !== 16'd4) begin bad++; $display("FAIL win_total got=%0d want=4", rd_b[0]); end
    endtask

    task automatic test_inflight_edges();
        do_reset();
        en = 1; tick();
        ar_hs = 2'b01; repeat (2) tick();
        ar_hs = 2'b01; r_last = 2'b01; tick();
        clear_inputs();
        total++; if (ar_if[0] !== 3'd2 || unf[0] !== 1'b0 || ovf[0] !== 1'b0) begin
            bad++; $display("FAIL same_cycle got=%0d unf=%b ovf=%b want 2/0/0", ar_if[0], unf[0], ovf[0]); end
        b_hs = 2'b01; tick(); b_hs = '0;
        total++; if (aw_if[0] !== 3'd0 || unf[0] !== 1'b1 || unf[1] !== 1'b0) begin
            bad++; $display("FAIL underflow got aw=%0d unf=%b want 0/01", aw_if[0], unf); end
        repeat (3) tick();
        total++; if (unf[0] !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b want=1", unf[0]); end
        ar_hs = 2'b10; repeat (8) tick(); ar_hs = '0;
        total++; if (ar_if[1] !== 3'd7 || ovf !== 2'b10) begin
            bad++; $display("FAIL overflow got ar1=%0d ovf=%b want 7/10", ar_if[1], ovf); end
    endtask

    task automatic test_timeout(input int pause);
        int n;
        bit seen;
        do_reset();
        en = 1; tick();
        aw_hs = 2'b10; tick(); aw_hs = '0;
        eos = 2'b11; tick();
        total++; if (state !== MON_DRAIN) begin bad++; $display("FAIL to_drain_entry got=%0d want=%0d", state, MON_DRAIN); end
        n = 0; seen = 0;
        while (n < 60 && !seen) begin
            en = (pause > 0 && n >= 3 && n < 3 + pause) ? 1'b0 : 1'b1;
            tick();
            n++;
            if (tmo === 1'b1) seen = 1;
        end
        en = 1;
        total++; if (!seen || n != DT + pause) begin
            bad++; $display("FAIL timeout_delay pause=%0d got=%0d want=%0d", pause, seen ? n : -1, DT + pause); end
        total++; if (state !== MON_TIMEOUT || done !== 1'b0 || aw_if[1] !== 3'd1) begin
            bad++; $display("FAIL timeout_state got state=%0d done=%b aw1=%0d want %0d/0/1", state, done, aw_if[1], MON_TIMEOUT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1; tick();
        ar_hs = 2'b11; aw_hs = 2'b01; r_hs = 2'b11; w_hs = 2'b10;
        repeat (5) tick();
        clear_inputs();
        total++; if (rd_b[0] !== 16'd5 || ar_if[1] !== 3'd5) begin
            bad++; $display("FAIL mid_pre got rd0=%0d ar1=%0d want 5/5", rd_b[0], ar_if[1]); end
        #2; rst_n = 1'b0; #1;
        total++; if (ar_if !== '0 || aw_if !== '0 || rd_b !== '0 || wr_b !== '0 || win_rd !== '0 ||
                     win_wr !== '0 || win_valid !== 1'b0 || done !== 1'b0 || tmo !== 1'b0 ||
                     unf !== '0 || ovf !== '0 || state !== MON_IDLE) begin
            bad++; $display("FAIL async_reset got ar=%h rd=%h state=%0d want all 0", ar_if, rd_b, state); end
        @(posedge clk); #1; rst_n = 1'b1; en = 1'b1;
        model_reset();
        tick();
        total++; if (win_valid !== 1'b0 || state !== MON_RUN) begin
            bad++; $display("FAIL post_reset got wv=%b state=%0d want 0/%0d", win_valid, state, MON_RUN); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < N; c++) begin
                ar_hs[c]  = ($urandom_range(0, 3) == 0);
                aw_hs[c]  = ($urandom_range(0, 3) == 0);
                r_hs[c]   = ($urandom_range(0, 1) == 0);
                w_hs[c]   = ($urandom_range(0, 1) == 0);
                r_last[c] = ($urandom_range(0, 3) == 0);
                b_hs[c]   = ($urandom_range(0, 3) == 0);
                eos[c]    = (cyc > 250) && ($urandom_range(0, 15) == 0);
            end
            tick();
            total++; if (state !== m_state || done !== m_done || tmo !== m_to || win_valid !== m_wv) begin
                bad++; $display("FAIL rnd_ctrl cyc=%0d got st=%0d d=%b t=%b wv=%b want st=%0d d=%b t=%b wv=%b",
                                cyc, state, done, tmo, win_valid, m_state, m_done, m_to, m_wv); end
            for (int c = 0; c < N; c++) begin
                total++; if (ar_if[c] !== IFW'(m_ar[c]) || aw_if[c] !== IFW'(m_aw[c]) ||
                             unf[c] !== m_unf[c] || ovf[c] !== m_ovf[c]) begin
                    bad++; $display("FAIL rnd_inflight cyc=%0d ch%0d got ar=%0d aw=%0d unf=%b ovf=%b want ar=%0d aw=%0d unf=%b ovf=%b",
                                    cyc, c, ar_if[c], aw_if[c], unf[c], ovf[c], m_ar[c], m_aw[c], m_unf[c], m_ovf[c]); end
                total++; if (rd_b[c] !== CW'(m_rd[c]) || wr_b[c] !== CW'(m_wr[c]) ||
                             win_rd[c] !== CW'(m_wrd[c]) || win_wr[c] !== CW'(m_wwr[c])) begin
                    bad++; $display("FAIL rnd_beats cyc=%0d ch%0d got rd=%0d wr=%0d wrd=%0d wwr=%0d want %0d %0d %0d %0d",
                                    cyc, c, rd_b[c], wr_b[c], win_rd[c], win_wr[c], m_rd[c], m_wr[c], m_wrd[c], m_wwr[c]); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clear_inputs();
        model_reset();
        test_reset();
        test_read_drain();
        test_window();
        test_inflight_edges();
        test_timeout(0);
        test_timeout(5);
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
